regfile_write_arbiter: RTL and testbench

// Shares the register file's single write port (address_d / data_dval / write_enable) between two

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/regfile_write_arbiter_fifo.sv | 98 +++++++++
 rtl/regfile_write_arbiter.sv | 130 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file writeback types and constants.
// Used by the write arbiter and its per-source FIFOs.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(
    input logic [REG_ADDR_W-1:0] a
  );
    reg_onehot    = '0;
    reg_onehot[a] = 1'b1;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_fifo.sv
// Small circular writeback FIFO, one per requester.
// Exposes a per-slot valid/addr view so the top can build the busy mask.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int QUEUE_DEPTH = 2
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   flush,
  input  logic                                   push,
  input  logic                                   pop,
  input  wb_entry_t                              push_entry,
  output logic                                   full,
  output logic                                   empty,
  output wb_entry_t                              head,
  output logic [QUEUE_DEPTH-1:0]                 ent_valid,
  output logic [QUEUE_DEPTH-1:0][REG_ADDR_W-1:0] ent_addr
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(QUEUE_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  wb_entry_t        mem_q [QUEUE_DEPTH];
  wb_entry_t        mem_d [QUEUE_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] bump(
    input logic [PTR_W-1:0] p
  );
    bump = (p == LAST_P) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (cnt_q == DEPTH_C);
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = bump(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = bump(rd_ptr_q);
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + ONE_C;
        2'b01:   cnt_d = cnt_q - ONE_C;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Slot i is live when its distance from the read pointer is below the count.
  always_comb begin
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      int off;
      off = i - int'(rd_ptr_q);
      if (off < 0) off = off + QUEUE_DEPTH;
      ent_valid[i] = (off < int'(cnt_q));
      ent_addr[i]  = mem_q[i].addr;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin share of the regfile write port between ALU and load writeback.
// Exports a busy mask of registers with writes queued or staged.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int QUEUE_DEPTH = 2,
  parameter int ADDR_W      = REG_ADDR_W,
  parameter int DATA_W      = REG_DATA_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [ADDR_W-1:0]   req0_addr,
  input  logic [DATA_W-1:0]   req0_data,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [ADDR_W-1:0]   req1_addr,
  input  logic [DATA_W-1:0]   req1_data,
  output logic [ADDR_W-1:0]   address_d,
  output logic [DATA_W-1:0]   data_dval,
  output logic                write_enable,
  output logic [NUM_REGS-1:0] busy
);

  logic      full0, empty0, full1, empty1;
  wb_entry_t head0, head1, pop_entry;
  logic      grant0, grant1, popped;
  logic      sel0, sel1;

  logic [QUEUE_DEPTH-1:0]                 ev0, ev1;
  logic [QUEUE_DEPTH-1:0][REG_ADDR_W-1:0] ea0, ea1;

  logic                  last_grant_q, last_grant_d;
  logic                  we_q, we_d;
  logic [REG_ADDR_W-1:0] addr_q, addr_d;
  logic [REG_DATA_W-1:0] data_q, data_d;
  logic [NUM_REGS-1:0]   busy_c;

  assign req0_ready = !full0 && !flush;
  assign req1_ready = !full1 && !flush;

  wb_fifo #(.QUEUE_DEPTH(QUEUE_DEPTH)) u_fifo0 (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .push       (req0_valid && req0_ready),
    .pop        (grant0),
    .push_entry ('{addr: req0_addr, data: req0_data}),
    .full       (full0),
    .empty      (empty0),
    .head       (head0),
    .ent_valid  (ev0),
    .ent_addr   (ea0)
  );

  wb_fifo #(.QUEUE_DEPTH(QUEUE_DEPTH)) u_fifo1 (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .push       (req1_valid && req1_ready),
    .pop        (grant1),
    .push_entry ('{addr: req1_addr, data: req1_data}),
    .full       (full1),
    .empty      (empty1),
    .head       (head1),
    .ent_valid  (ev1),
    .ent_addr   (ea1)
  );

  // last_grant holds the index of the source served most recently.
  assign sel0 = !empty0 && (empty1 || last_grant_q);
  assign sel1 = !empty1 && (empty0 || !last_grant_q);

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!flush) begin
      unique case (1'b1)
        sel0:    grant0 = 1'b1;
        sel1:    grant1 = 1'b1;
        default: ;
      endcase
    end
  end

  assign popped    = grant0 || grant1;
  assign pop_entry = grant1 ? head1 : head0;

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant0) last_grant_d = 1'b0;
    if (grant1) last_grant_d = 1'b1;
    we_d   = popped && (pop_entry.addr != ZERO_REG);
    addr_d = we_d ? pop_entry.addr : addr_q;
    data_d = we_d ? pop_entry.data : data_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
    end
  end

  assign write_enable = we_q;
  assign address_d    = addr_q;
  assign data_dval    = data_q;

  always_comb begin
    busy_c = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (ev0[i]) busy_c = busy_c | reg_onehot(ea0[i]);
      if (ev1[i]) busy_c = busy_c | reg_onehot(ea1[i]);
    end
    if (we_q) busy_c = busy_c | reg_onehot(addr_q);
    busy_c[ZERO_REG] = 1'b0;
  end

  assign busy = busy_c;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: queue-based model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_regfile_write_arbiter;

  localparam int D = 2;

  logic        clock = 1'b0;
  logic        reset, flush;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic [4:0]  address_d;
  logic [31:0] data_dval;
  logic        write_enable;
  logic [31:0] busy;

  always #5 clock = ~clock;

  regfile_write_arbiter #(.QUEUE_DEPTH(D)) dut (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_addr    (req0_addr),
    .req0_data    (req0_data),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_addr    (req1_addr),
    .req1_data    (req1_data),
    .address_d    (address_d),
    .data_dval    (data_dval),
    .write_enable (write_enable),
    .busy         (busy)
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        q0[$];
  ent_t        q1[$];
  bit          m_lg;
  bit          m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] b;
    b = '0;
    foreach (q0[i]) b[q0[i].a] = 1'b1;
    foreach (q1[i]) b[q1[i].a] = 1'b1;
    if (m_we) b[m_addr] = 1'b1;
    b[0] = 1'b0;
    return b;
  endfunction

  task automatic compare();
    chk("ready0", req0_ready, (q0.size() < D) && !flush);
    chk("ready1", req1_ready, (q1.size() < D) && !flush);
    chk("we", write_enable, m_we);
    chk("busy", busy, model_busy());
    if (m_we) begin
      chk("addr", address_d, m_addr);
      chk("data", data_dval, m_data);
    end
  endtask

  task automatic model_advance();
    bit   r0, r1, g0, g1;
    ent_t e;
    if (reset) begin
      q0.delete(); q1.delete();
      m_lg = 1; m_we = 0; m_addr = '0; m_data = '0;
    end else if (flush) begin
      q0.delete(); q1.delete();
      m_we = 0;
    end else begin
      r0 = q0.size() < D;
      r1 = q1.size() < D;
      g0 = (q0.size() > 0) && (q1.size() == 0 || m_lg);
      g1 = !g0 && (q1.size() > 0);
      m_we = 0;
      e = '{a: '0, d: '0};
      if (g0) begin e = q0.pop_front(); m_lg = 0; end
      if (g1) begin e = q1.pop_front(); m_lg = 1; end
      if ((g0 || g1) && e.a != 0) begin
        m_we = 1; m_addr = e.a; m_data = e.d;
      end
      if (req0_valid && r0) q0.push_back('{a: req0_addr, d: req0_data});
      if (req1_valid && r1) q1.push_back('{a: req1_addr, d: req1_data});
    end
  endtask

  task automatic step();
    #1;
    compare();
    model_advance();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit v0, input logic [4:0] a0,
                       input logic [31:0] d0, input bit v1,
                       input logic [4:0] a1, input logic [31:0] d1);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
  endtask

  task automatic idle();
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
  endtask

  logic [4:0] exp_order [4];

  initial begin
    reset = 1; flush = 0;
    idle();
    repeat (2) @(posedge clock);
    model_advance();
    #1;
    reset = 0;
    #1;
    chk("rst_we", write_enable, 0);
    chk("rst_addr", address_d, 0);
    chk("rst_data", data_dval, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready0", req0_ready, 1);
    chk("rst_ready1", req1_ready, 1);

    // single ALU write and its latency
    drive(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0);
    step();
    idle();
    chk("t1_busy_q", busy, 32'h0000_0020);
    chk("t1_we_e0", write_enable, 0);
    step();
    chk("t1_we", write_enable, 1);
    chk("t1_addr", address_d, 5);
    chk("t1_data", data_dval, 32'hDEADBEEF);
    step();
    chk("t1_we_off", write_enable, 0);
    chk("t1_busy_clr", busy, 0);

    // contention: last grant was req0, so req1 goes first
    exp_order = '{5'd3, 5'd1, 5'd4, 5'd2};
    drive(1, 5'd1, 32'h11, 1, 5'd3, 32'h33);
    step();
    drive(1, 5'd2, 32'h22, 1, 5'd4, 32'h44);
    step();
    idle();
    chk("t2_we0", write_enable, 1);
    chk("t2_ord0", address_d, exp_order[0]);
    for (int k = 1; k < 4; k++) begin
      step();
      chk("t2_we", write_enable, 1);
      chk("t2_ord", address_d, exp_order[k]);
    end
    step();
    chk("t2_tail", write_enable, 0);

    // backpressure, then flush
    drive(1, 5'd12, 32'hC0, 1, 5'd13, 32'hD0);
    #1;
    chk("t3_rdy_a", req0_ready, 1);
    step();
    chk("t3_rdy_b", req0_ready, 1);
    step();
    chk("t3_rdy_full", req0_ready, 0);
    flush = 1;
    #1;
    chk("t3_fl_rdy0", req0_ready, 0);
    chk("t3_fl_rdy1", req1_ready, 0);
    step();
    flush = 0;
    chk("t3_fl_busy", busy, 0);
    chk("t3_fl_we", write_enable, 0);
    drive(1, 5'd9, 32'h99, 0, 5'd0, 32'h0);
    step();
    idle();
    chk("t3_refill", busy, 32'h0000_0200);
    step();
    chk("t3_we9", write_enable, 1);
    chk("t3_addr9", address_d, 9);

    // writes to x0 are swallowed
    drive(1, 5'd0, 32'h1234, 0, 5'd0, 32'h0);
    step();
    drive(1, 5'd6, 32'h66, 0, 5'd0, 32'h0);
    step();
    idle();
    chk("t4_we0", write_enable, 0);
    chk("t4_busy", busy, 32'h0000_0040);
    step();
    chk("t4_we6", write_enable, 1);
    chk("t4_addr6", address_d, 6);
    chk("t4_data6", data_dval, 32'h66);

    // flush with a staged write and both queues occupied
    drive(1, 5'd7, 32'h77, 0, 5'd0, 32'h0);
    step();
    drive(1, 5'd8, 32'h88, 1, 5'd10, 32'hAA);
    step();
    idle();
    chk("t5_stage_we", write_enable, 1);
    chk("t5_stage_a", address_d, 7);
    chk("t5_busy_pre", busy, 32'h0000_0580);
    flush = 1;
    step();
    flush = 0;
    chk("t5_fl_we", write_enable, 0);
    chk("t5_fl_busy", busy, 0);
    step();
    chk("t5_no_wr", write_enable, 0);

    // reset beats flush
    drive(1, 5'd11, 32'hB1, 1, 5'd12, 32'hB2);
    step();
    idle();
    reset = 1; flush = 1;
    step();
    reset = 0; flush = 0;
    chk("t5_rst_we", write_enable, 0);
    chk("t5_rst_addr", address_d, 0);
    chk("t5_rst_data", data_dval, 0);
    chk("t5_rst_busy", busy, 0);
    drive(1, 5'd14, 32'hE0, 1, 5'd15, 32'hF0);
    step();
    idle();
    step();
    chk("t5_rst_lg", address_d, 14);

    // random soak against the queue model
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 599) == 0);
      flush = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 9) < 6, 5'($urandom_range(0, 31)),
            $urandom,
            $urandom_range(0, 9) < 6, 5'($urandom_range(0, 31)),
            $urandom);
      step();
    end
    reset = 0; flush = 0;
    idle();
    repeat (6) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
